// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I opcodes, ALU op codes, mux selects and control states
package riscv_pkg;

    // ALU operation codes shared by the control FSM and the ALU.
    // 0x0F is reserved so the unsigned branch compares sit at 0x10/0x11.
    localparam logic [4:0] ALU_ADD   = 5'h00;
    localparam logic [4:0] ALU_SUB   = 5'h01;
    localparam logic [4:0] ALU_SLL   = 5'h02;
    localparam logic [4:0] ALU_SLT   = 5'h03;
    localparam logic [4:0] ALU_SLTU  = 5'h04;
    localparam logic [4:0] ALU_XOR   = 5'h05;
    localparam logic [4:0] ALU_SRL   = 5'h06;
    localparam logic [4:0] ALU_SRA   = 5'h07;
    localparam logic [4:0] ALU_OR    = 5'h08;
    localparam logic [4:0] ALU_AND   = 5'h09;
    localparam logic [4:0] ALU_BEQ   = 5'h0A;
    localparam logic [4:0] ALU_BNE   = 5'h0B;
    localparam logic [4:0] ALU_BLT   = 5'h0C;
    localparam logic [4:0] ALU_BGE   = 5'h0D;
    localparam logic [4:0] ALU_AUIPC = 5'h0E;
    localparam logic [4:0] ALU_BLTU  = 5'h10;
    localparam logic [4:0] ALU_BGEU  = 5'h11;

    // Major opcodes (instr[6:0])
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        A_RS1    = 2'd0,
        A_PC     = 2'd1,
        A_OLD_PC = 2'd2,
        A_ZERO   = 2'd3
    } a_sel_e;

    typedef enum logic [1:0] {
        B_RS2  = 2'd0,
        B_IMM  = 2'd1,
        B_FOUR = 2'd2
    } b_sel_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC  = 2'd2
    } wb_sel_e;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

endpackage

// File: rtl/multicycle_ctrl_alu_decoder.sv
// rtl/multicycle_ctrl_alu_decoder.sv - maps opcode/funct3/funct7[5] to an ALU op code
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_b5_i,
    output logic [4:0] alu_op_o
);

    // Pure decode; opcodes without a dedicated operation fall back to ADD
    always_comb begin
        alu_op_o = ALU_ADD;
        case (opcode_i)
            OP_REG, OP_IMM: begin
                case (funct3_i)
                    3'b000:  alu_op_o = (opcode_i == OP_REG && funct7_b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op_o = ALU_SLL;
                    3'b010:  alu_op_o = ALU_SLT;
                    3'b011:  alu_op_o = ALU_SLTU;
                    3'b100:  alu_op_o = ALU_XOR;
                    3'b101:  alu_op_o = funct7_b5_i ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op_o = ALU_OR;
                    default: alu_op_o = ALU_AND;
                endcase
            end
            OP_BRANCH: begin
                case (funct3_i)
                    3'b001:  alu_op_o = ALU_BNE;
                    3'b100:  alu_op_o = ALU_BLT;
                    3'b101:  alu_op_o = ALU_BGE;
                    3'b110:  alu_op_o = ALU_BLTU;
                    3'b111:  alu_op_o = ALU_BGEU;
                    default: alu_op_o = ALU_BEQ;
                endcase
            end
            OP_AUIPC: alu_op_o = ALU_AUIPC;
            default:  alu_op_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM (option: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN)
module multicycle_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    input  logic        alu_zero_bit,
    output logic [4:0]  alu_op,
    output logic [1:0]  alu_a_sel,
    output logic [1:0]  alu_b_sel,
    output logic [2:0]  imm_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        old_pc_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_out_write,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        mem_timeout,
    output logic [2:0]  state_dbg
);

    // 0 means "never flag": the counter then just parks at its maximum
    localparam logic [7:0] WAIT_LIMIT = (MEM_TIMEOUT == 0) ? 8'hFF : 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] dec_op;
    logic       r_funct7_ok;
    logic       unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign funct7       = instr[31:25];
    assign r_funct7_ok  = (funct7 == 7'h00) || (funct7 == 7'h20);
    assign unused_instr = ^{instr[24:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .funct7_b5_i (funct7[5]),
        .alu_op_o    (dec_op)
    );

    // Control outputs and next state from state, IR and memory handshake
    always_comb begin
        alu_op        = ALU_ADD;
        alu_a_sel     = A_RS1;
        alu_b_sel     = B_RS2;
        imm_sel       = IMM_I;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        old_pc_write  = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        alu_out_write = 1'b0;
        reg_write     = 1'b0;
        wb_sel        = WB_ALU;
        state_d       = state_q;

        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write     = 1'b1;
                    old_pc_write = 1'b1;
                    pc_write     = 1'b1;
                    alu_a_sel    = A_PC;
                    alu_b_sel    = B_FOUR;
                    state_d      = ST_DECODE;
                end
            end
            ST_DECODE: begin
                // Precompute old_pc + imm so branches/JAL find their target in alu_out
                alu_a_sel     = A_OLD_PC;
                alu_b_sel     = B_IMM;
                imm_sel       = (opcode == OP_BRANCH) ? IMM_B :
                                (opcode == OP_JAL)    ? IMM_J : IMM_I;
                alu_out_write = 1'b1;
                state_d       = ST_EXEC;
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (opcode)
                    OP_REG: begin
                        if (r_funct7_ok) begin
                            alu_op        = dec_op;
                            alu_out_write = 1'b1;
                            state_d       = ST_WB;
                        end else begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                            state_d = ST_TRAP;
`endif
                        end
                    end
                    OP_IMM: begin
                        alu_b_sel     = B_IMM;
                        alu_op        = dec_op;
                        alu_out_write = 1'b1;
                        state_d       = ST_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_b_sel     = B_IMM;
                        imm_sel       = (opcode == OP_STORE) ? IMM_S : IMM_I;
                        alu_out_write = 1'b1;
                        state_d       = ST_MEM;
                    end
                    OP_BRANCH: begin
                        alu_op   = dec_op;
                        pc_write = alu_zero_bit;
                        pc_src   = 1'b1;
                    end
                    OP_JAL: begin
                        pc_write  = 1'b1;
                        pc_src    = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC;
                    end
                    OP_JALR: begin
                        // Link value is the PC before this cycle's update (old_pc + 4)
                        alu_b_sel = B_IMM;
                        pc_write  = 1'b1;
                        reg_write = 1'b1;
                        wb_sel    = WB_PC;
                    end
                    OP_LUI: begin
                        alu_a_sel     = A_ZERO;
                        alu_b_sel     = B_IMM;
                        imm_sel       = IMM_U;
                        alu_out_write = 1'b1;
                        state_d       = ST_WB;
                    end
                    OP_AUIPC: begin
                        alu_a_sel     = A_OLD_PC;
                        alu_b_sel     = B_IMM;
                        imm_sel       = IMM_U;
                        alu_op        = dec_op;
                        alu_out_write = 1'b1;
                        state_d       = ST_WB;
                    end
                    default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                        state_d = ST_TRAP;
`endif
                    end
                endcase
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (opcode == OP_STORE);
                if (mem_ready) begin
                    state_d = ST_FETCH;
                    if (opcode == OP_LOAD) begin
                        reg_write = 1'b1;
                        wb_sel    = WB_MEM;
                    end
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase

        // Reset abandons the instruction: nothing may be written this cycle
        if (reset) begin
            alu_op        = '0;
            alu_a_sel     = '0;
            alu_b_sel     = '0;
            imm_sel       = '0;
            mem_req       = 1'b0;
            mem_we        = 1'b0;
            mem_addr_sel  = 1'b0;
            ir_write      = 1'b0;
            old_pc_write  = 1'b0;
            pc_write      = 1'b0;
            pc_src        = 1'b0;
            alu_out_write = 1'b0;
            reg_write     = 1'b0;
            wb_sel        = '0;
        end
    end

    assign state_dbg   = reset ? 3'd0 : state_q;
    assign mem_timeout = timeout_q && !reset && (state_q != ST_TRAP);

    // Consecutive memory wait cycles, saturating; the flag is sticky until reset
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (mem_req && mem_ready) begin
            wait_cnt_d = '0;
        end else if (mem_req) begin
            if (wait_cnt_q != WAIT_LIMIT) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
            if (MEM_TIMEOUT != 0 && wait_cnt_d == WAIT_LIMIT) begin
                timeout_d = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Wait counter and timeout flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

endmodule
